// File: rtl/mem_pkg.sv
// Shared constants and types for the banked memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mem_pkg;

  // Four interleaved banks, selected by the low word-offset bits of the byte address
  localparam int NUM_BANKS = 4;
  localparam int BANK_LSB  = 1;
  localparam int BANK_MSB  = 2;

  // Fixed read return latency and default bank occupancy
  localparam int RD_LATENCY       = 2;
  localparam int BANK_CYCLES_DFLT = 4;

  // Word width carried by the read pipeline; the responder's DATA_W must match
  localparam int PIPE_DATA_W = 16;

  // One read-pipeline stage: data is forced to zero whenever vld is low
  typedef struct packed {
    logic                   vld;
    logic [PIPE_DATA_W-1:0] dat;
  } rd_stage_t;

endpackage

// File: rtl/bank_busy_ctr.sv
// Per-bank occupancy countdown: loads on accept, counts to zero, flags nonzero.
// Latency: busy rises the cycle after load and stays up for LOAD_VAL cycles.
// Backpressure: none internally; busy is the back-pressure source for the bank.
module bank_busy_ctr #(
  parameter int CNT_W    = 2,
  parameter int LOAD_VAL = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic busy
);

  logic [CNT_W-1:0] cnt;

  // Reload on an accepted access, otherwise count down to zero and hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(LOAD_VAL);
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/bank_mem_responder.sv
// Four-bank word memory; writes land at the accept edge, reads return 2 cycles after accept.
// Latency: read data + rd_valid in cycle N+2 for a read accepted in cycle N; in issue order.
// Backpressure: combinational stall when the addressed bank is busy; MEM_ERR_CHECK_EN adds err on bad requests.
module bank_mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = PIPE_DATA_W,
  parameter int DEPTH_W     = 12,
  parameter int BANK_CYCLES = BANK_CYCLES_DFLT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mem_wr,
  input  logic                 mem_rd,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [DATA_W-1:0]    data_in,
  output logic [DATA_W-1:0]    data_out,
  output logic                 rd_valid,
  output logic                 stall,
  output logic [NUM_BANKS-1:0] busy,
  output logic                 err
);

  localparam int CNT_W = (BANK_CYCLES > 2) ? $clog2(BANK_CYCLES) : 1;

  logic [BANK_MSB-BANK_LSB:0] bank;
  logic [DEPTH_W-1:0]         idx;
  logic                       req;
  logic                       bad_req;
  logic                       accept;
  logic                       wr_en;
  logic                       rd_en;
  logic [DATA_W-1:0]          mem [2**DEPTH_W];
  rd_stage_t                  stage1;
  rd_stage_t                  stage2;

  assign bank = addr[BANK_MSB:BANK_LSB];
  assign idx  = addr[DEPTH_W:1];
  assign req  = mem_wr | mem_rd;

  // Address bits above the stored depth (and addr[0] without checking) are don't-care
  logic unused_addr;
  assign unused_addr = ^{addr[ADDR_W-1:DEPTH_W+1], addr[0]};

`ifdef MEM_ERR_CHECK_EN
  // Unaligned or read+write requests are dropped and reported, never stalled
  assign bad_req = req & (addr[0] | (mem_wr & mem_rd));

  // One-cycle error pulse for the request seen in the previous cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else begin
      err <= bad_req;
    end
  end
`else
  assign bad_req = 1'b0;
  assign err     = 1'b0;
`endif

  assign stall  = req & ~bad_req & busy[bank];
  assign accept = req & ~bad_req & ~busy[bank];
  // Write wins when both strobes are set, so no read is issued in that case
  assign wr_en  = accept & mem_wr;
  assign rd_en  = accept & mem_rd & ~mem_wr;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    bank_busy_ctr #(
      .CNT_W   (CNT_W),
      .LOAD_VAL(BANK_CYCLES - 1)
    ) u_busy_ctr (
      .clk  (clk),
      .rst_n(rst_n),
      .load (accept && (bank == 2'(b))),
      .busy (busy[b])
    );
  end

  // Storage array is not reset; accepted writes update it at the accept edge
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[idx] <= data_in;
    end
  end

  // Two-stage read pipeline; reset drops any reads still in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage1 <= '0;
      stage2 <= '0;
    end else begin
      stage1.vld <= rd_en;
      stage1.dat <= rd_en ? mem[idx] : '0;
      stage2     <= stage1;
    end
  end

  assign rd_valid = stage2.vld;
  assign data_out = stage2.dat;

endmodule

// File: tb/tb_bank_mem_responder.sv
// Directed bench for bank_mem_responder with hand-computed expectations.
// Latency: checks the N+2 read return and N+1..N+3 bank occupancy.
// Backpressure: checks stall on same-bank conflict and stream-without-stall on interleaved offsets.
module tb_bank_mem_responder;

  logic        clk;
  logic        rst_n;
  logic        mem_wr;
  logic        mem_rd;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        rd_valid;
  logic        stall;
  logic [3:0]  busy;
  logic        err;

  int checks;
  int failures;

  bank_mem_responder dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .mem_wr  (mem_wr),
    .mem_rd  (mem_rd),
    .addr    (addr),
    .data_in (data_in),
    .data_out(data_out),
    .rd_valid(rd_valid),
    .stall   (stall),
    .busy    (busy),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge: the start of a new cycle
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drive this cycle's request and let combinational outputs settle
  task automatic drv(input logic w, input logic r, input logic [15:0] a, input logic [15:0] d);
    mem_wr  = w;
    mem_rd  = r;
    addr    = a;
    data_in = d;
    #1;
  endtask

  task automatic idle;
    drv(1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  // One write, then idle until the bank is free again (4 cycles total)
  task automatic write_word(input logic [15:0] a, input logic [15:0] d);
    drv(1'b1, 1'b0, a, d);
    chk("wr_stall", stall, 1'b0);
    tick;
    idle;
    repeat (3) tick;
  endtask

  // One read, checking the N+1 gap and the N+2 return; ends in cycle N+4
  task automatic read_check(input string tag, input logic [15:0] a, input logic [15:0] exp);
    drv(1'b0, 1'b1, a, 16'h0000);
    chk({tag, "_stall"}, stall, 1'b0);
    tick;
    idle;
    chk({tag, "_vld_n1"}, rd_valid, 1'b0);
    tick;
    chk({tag, "_vld_n2"}, rd_valid, 1'b1);
    chk({tag, "_dat_n2"}, data_out, exp);
    tick;
    chk({tag, "_vld_n3"}, rd_valid, 1'b0);
    chk({tag, "_dat_n3"}, data_out, 16'h0000);
    tick;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    mem_wr   = 1'b0;
    mem_rd   = 1'b0;
    addr     = 16'h0000;
    data_in  = 16'h0000;

    // Reset state
    repeat (2) tick;
    chk("rst_busy", busy, 4'b0000);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_data_out", data_out, 16'h0000);
    chk("rst_err", err, 1'b0);
    chk("rst_stall", stall, 1'b0);
    rst_n = 1'b1;
    tick;

    // Write 0xBEEF to 0x0010, read it back in cycle 4
    drv(1'b1, 1'b0, 16'h0010, 16'hBEEF);
    chk("t1_wr_stall", stall, 1'b0);
    tick;
    idle;
    chk("t1_busy_c1", busy, 4'b0001);
    repeat (3) tick;
    chk("t1_busy_c4", busy, 4'b0000);
    read_check("t1_rd", 16'h0010, 16'hBEEF);

    // Interleaved line write then line read: no stalls, data in cycles 6..9
    for (int c = 0; c < 12; c++) begin
      if (c < 4)      drv(1'b1, 1'b0, 16'h0100 + 16'(2 * c), 16'(16'h1111 * (c + 1)));
      else if (c < 8) drv(1'b0, 1'b1, 16'h0100 + 16'(2 * (c - 4)), 16'h0000);
      else            idle;
      chk("t2_stall", stall, 1'b0);
      if (c == 4) chk("t2_busy_c4", busy, 4'b1110);
      chk("t2_rd_valid", rd_valid, (c >= 6 && c <= 9) ? 1'b1 : 1'b0);
      chk("t2_data_out", data_out, (c >= 6 && c <= 9) ? 16'(16'h1111 * (c - 5)) : 16'h0000);
      tick;
    end

    // Same-bank conflict: 0x0028 stalls in cycles 1..3, accepted in cycle 4
    write_word(16'h0020, 16'hA0A0);
    write_word(16'h0028, 16'hB0B0);
    for (int c = 0; c < 9; c++) begin
      if (c == 0)      drv(1'b0, 1'b1, 16'h0020, 16'h0000);
      else if (c <= 4) drv(1'b0, 1'b1, 16'h0028, 16'h0000);
      else             idle;
      chk("t3_stall", stall, (c >= 1 && c <= 3) ? 1'b1 : 1'b0);
      chk("t3_rd_valid", rd_valid, (c == 2 || c == 6) ? 1'b1 : 1'b0);
      chk("t3_data_out", data_out, (c == 2) ? 16'hA0A0 : (c == 6) ? 16'hB0B0 : 16'h0000);
      tick;
    end

    // Reset while a read is in flight drops the return
    drv(1'b0, 1'b1, 16'h0040, 16'h0000);
    chk("t4_stall", stall, 1'b0);
    tick;
    idle;
    rst_n = 1'b0;
    #1;
    chk("t4_busy_in_rst", busy, 4'b0000);
    chk("t4_vld_in_rst", rd_valid, 1'b0);
    tick;
    rst_n = 1'b1;
    #1;
    chk("t4_busy_c2", busy, 4'b0000);
    for (int c = 2; c < 8; c++) begin
      chk("t4_rd_valid", rd_valid, 1'b0);
      tick;
    end

`ifdef MEM_ERR_CHECK_EN
    // Unaligned write is dropped with an error pulse
    write_word(16'h0030, 16'h7777);
    drv(1'b1, 1'b0, 16'h0031, 16'hDEAD);
    chk("t5_unal_stall", stall, 1'b0);
    tick;
    idle;
    chk("t5_unal_err", err, 1'b1);
    chk("t5_unal_busy", busy, 4'b0000);
    tick;
    chk("t5_err_clear", err, 1'b0);
    read_check("t5_rd30", 16'h0030, 16'h7777);

    // Read+write together is dropped with an error pulse, no read return
    drv(1'b1, 1'b1, 16'h0032, 16'h5A5A);
    chk("t5_rw_stall", stall, 1'b0);
    tick;
    idle;
    chk("t5_rw_err", err, 1'b1);
    chk("t5_rw_busy", busy, 4'b0000);
    for (int c = 1; c < 4; c++) begin
      chk("t5_rw_vld", rd_valid, 1'b0);
      tick;
    end

    // Erroring request to a busy bank reports err, not stall
    drv(1'b0, 1'b1, 16'h0030, 16'h0000);
    tick;
    drv(1'b1, 1'b0, 16'h0031, 16'h1234);
    chk("t5_busy_bank", busy, 4'b0001);
    chk("t5_err_not_stall", stall, 1'b0);
    tick;
    idle;
    chk("t5_busy_err", err, 1'b1);
    repeat (3) tick;
    read_check("t5_rd30_again", 16'h0030, 16'h7777);
`else
    // Read+write together: write wins, no read return, no error
    drv(1'b1, 1'b1, 16'h0032, 16'h5A5A);
    chk("t5_rw_stall", stall, 1'b0);
    tick;
    idle;
    for (int c = 1; c < 5; c++) begin
      chk("t5_rw_vld", rd_valid, 1'b0);
      chk("t5_rw_err", err, 1'b0);
      tick;
    end
    read_check("t5_rd32", 16'h0032, 16'h5A5A);
    chk("t5_err_end", err, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
